// File: rtl/alu_pipe_if.sv
// Issue/writeback handshake bundle for alu_pipe: producer drives the in_* side,
// consumer drives out_ready; the ALU is the slave on both.
interface alu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       flags;

    modport master (
        output in_valid, in_op, op1, op2, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, flags
    );

    modport slave (
        input  in_valid, in_op, op1, op2, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// Elastic in-order ALU pipeline: ALU evaluated on entry, PIPE_STAGES register
// stages, final stage hosts a restoring divider that stalls the pipe while iterating.
module alu_pipe #(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_pipe_if.slave bus
);
    localparam int P   = PIPE_STAGES;
    localparam int SHW = $clog2(XLEN);
    localparam int M   = XLEN - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    typedef struct packed {
        logic             is_div;
        logic             is_rem;
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
        logic [XLEN-1:0]  opb;
    } payload_t;

    // Index 0 is the combinational entry point; P-1 feeds the final stage.
    logic     w_vld  [0:P-1];
    payload_t w_data [0:P-1];
    logic     w_take [1:P];

    payload_t        w_alu;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_dif;

    assign w_sum = {1'b0, bus.op1} + {1'b0, bus.op2};
    assign w_dif = {1'b0, bus.op1} + {1'b0, ~bus.op2} + (XLEN+1)'(1);

    always_comb begin
        w_alu     = '0;
        w_alu.tag = bus.in_tag;
        w_alu.opb = bus.op2;
        case (bus.in_op)
            4'd0: begin
                w_alu.res      = w_sum[M:0];
                w_alu.flags[1] = w_sum[XLEN];
                w_alu.flags[2] = (bus.op1[M] == bus.op2[M]) && (w_sum[M] != bus.op1[M]);
            end
            4'd1: begin
                w_alu.res      = w_dif[M:0];
                w_alu.flags[1] = w_dif[XLEN];
                w_alu.flags[2] = (bus.op1[M] != bus.op2[M]) && (w_dif[M] != bus.op1[M]);
            end
            4'd2:  w_alu.res = bus.op1 & bus.op2;
            4'd3:  w_alu.res = bus.op1 | bus.op2;
            4'd4:  w_alu.res = bus.op1 ^ bus.op2;
            4'd5:  w_alu.res = bus.op1 << bus.op2[SHW-1:0];
            4'd6:  w_alu.res = bus.op1 >> bus.op2[SHW-1:0];
            4'd7:  w_alu.res = $unsigned($signed(bus.op1) >>> bus.op2[SHW-1:0]);
            4'd8:  w_alu.res = {{(XLEN-1){1'b0}}, $signed(bus.op1) < $signed(bus.op2)};
            4'd9:  w_alu.res = {{(XLEN-1){1'b0}}, bus.op1 < bus.op2};
            4'd10: w_alu.res = bus.op1 * bus.op2;
            4'd11: begin
                w_alu.is_div = 1'b1;
                w_alu.res    = bus.op1;
            end
            4'd12: begin
                w_alu.is_div = 1'b1;
                w_alu.is_rem = 1'b1;
                w_alu.res    = bus.op1;
            end
            default: w_alu.flags[3] = 1'b1;
        endcase
        // Divide zero flag is only known once the divider finishes.
        if (!w_alu.flags[3] && !w_alu.is_div)
            w_alu.flags[0] = (w_alu.res == '0);
    end

    assign w_vld[0]     = bus.in_valid;
    assign w_data[0]    = w_alu;
    assign bus.in_ready = rst & w_take[1];

    genvar gi;
    generate
        for (gi = 1; gi < P; gi++) begin : g_stage
            logic     r_vld;
            payload_t r_data;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else if (w_take[gi]) begin
                    r_vld  <= w_vld[gi-1];
                    r_data <= w_data[gi-1];
                end
            end

            assign w_take[gi] = !r_vld || w_take[gi+1];
            assign w_vld[gi]  = r_vld;
            assign w_data[gi] = r_data;
        end
    endgenerate

    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_res;
    logic [3:0]       r_flags;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_dvs;
    logic             r_is_rem;
    logic [SHW-1:0]   r_cnt;

    logic             w_fin_load;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_trial;
    logic             w_ge;
    logic [XLEN-1:0]  w_rem_nx;
    logic [XLEN-1:0]  w_quo_nx;
    logic [XLEN-1:0]  w_div_res;

    assign w_take[P]  = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.out_ready);
    assign w_fin_load = w_vld[P-1] && w_take[P];

    // Restoring step: quotient register doubles as the dividend shifter.
    assign w_shift   = {r_rem, r_quo[M]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_ge      = !w_trial[XLEN];
    assign w_rem_nx  = w_ge ? w_trial[M:0] : w_shift[M:0];
    assign w_quo_nx  = {r_quo[M-1:0], w_ge};
    assign w_div_res = r_is_rem ? w_rem_nx : w_quo_nx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_res    <= '0;
            r_flags  <= '0;
            r_tag    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_state <= S_HOLD;
                r_res   <= w_div_res;
                r_flags <= {3'b000, w_div_res == '0};
            end
        end else if (w_fin_load) begin
            r_tag <= w_data[P-1].tag;
            if (w_data[P-1].is_div) begin
                r_state  <= S_DIV;
                r_quo    <= w_data[P-1].res;
                r_rem    <= '0;
                r_dvs    <= w_data[P-1].opb;
                r_is_rem <= w_data[P-1].is_rem;
                r_cnt    <= SHW'(XLEN - 1);
            end else begin
                r_state <= S_HOLD;
                r_res   <= w_data[P-1].res;
                r_flags <= w_data[P-1].flags;
            end
        end else if ((r_state == S_HOLD) && bus.out_ready) begin
            r_state <= S_IDLE;
        end
    end

    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.result    = r_res;
    assign bus.out_tag   = r_tag;
    assign bus.flags     = r_flags;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results on accept, an
// independent monitor pops and compares on every output handshake.
module tb_alu_pipe;
    localparam int XLEN  = 32;
    localparam int P     = 2;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_pipe #(.XLEN(XLEN), .PIPE_STAGES(P), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
        bit          div;
    } exp_t;

    exp_t scb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_force = 1'b1;
    bit   watch = 1'b0;
    bit   saw_block = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: result and {illegal, overflow, carry, zero} from plain arithmetic.
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c, v, ill;
        logic [32:0] w;
        longint      sa, sb, sr;
        r = 32'd0; c = 1'b0; v = 1'b0; ill = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                sr = sa + sb;
                v = (sr != longint'($signed(r)));
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                sr = sa - sb;
                v = (sr != longint'($signed(r)));
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = $unsigned($signed(a) >>> b[4:0]);
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = a * b;
            4'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: r = (b == 0) ? a : a % b;
            default: ill = 1'b1;
        endcase
        return {ill, v, c, (!ill && r == 32'd0), r};
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // out_ready driver, offset from the main process to avoid races.
    initial forever begin
        @(posedge clk);
        #2;
        bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    initial forever begin
        @(negedge clk);
        if (watch && rst === 1'b1 && bus.in_ready === 1'b0) saw_block = 1'b1;
    end

    // Monitor: latency on first appearance, stability under stall, values on handshake.
    bit          seen = 1'b0;
    bit          stall_prev = 1'b0;
    logic [39:0] held;
    initial forever begin
        @(negedge clk);
        if (rst !== 1'b1) begin
            seen = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", 64'({bus.result, bus.out_tag, bus.flags}), 64'(held));
            end
            stall_prev = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (scb.size() == 0) begin
                    chk("spurious_out", 64'(scb.size()), 64'd1);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (scb[0].lat)
                            chk("latency", 64'(cyc - scb[0].acc), scb[0].div ? 64'(P + XLEN) : 64'(P));
                    end
                    if (bus.out_ready === 1'b1) begin
                        exp_t e;
                        e = scb.pop_front();
                        $display("out tag=%0d result=%h flags=%b (exp %h/%b) cycle %0d",
                                 bus.out_tag, bus.result, bus.flags, e.res, e.flg, cyc);
                        chk("result", 64'(bus.result), 64'(e.res));
                        chk("flags", 64'(bus.flags), 64'(e.flg));
                        chk("tag", 64'(bus.out_tag), 64'(e.tag));
                        seen = 1'b0;
                    end else begin
                        stall_prev = 1'b1;
                        held = {bus.result, bus.out_tag, bus.flags};
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input bit lat);
        bit          done;
        logic [35:0] m;
        exp_t        e;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.op1      = a;
        bus.op2      = b;
        bus.in_tag   = tag;
        for (int w = 0; w < 300 && !done; w++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                m = model(op, a, b);
                e.res = m[31:0];
                e.flg = m[35:32];
                e.tag = tag;
                e.acc = cyc;
                e.lat = lat;
                e.div = (op == 4'd11 || op == 4'd12);
                scb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("issue_accept", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 3000 && scb.size() != 0; w++) @(posedge clk);
        #1;
        chk("drain", 64'(scb.size()), 64'd0);
    endtask

    initial begin
        logic [3:0] op;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 4'd0;
        bus.op1 = '0;
        bus.op2 = '0;
        bus.in_tag = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 4'd1, 1'b1);
        issue(4'd1, 32'd5, 32'd5, 4'd2, 1'b1);
        wait_drain();

        issue(4'd0, 32'($urandom), 32'($urandom), 4'd0, 1'b1);
        issue(4'd1, 32'd3, 32'd9, 4'd1, 1'b1);
        issue(4'd2, 32'($urandom), 32'($urandom), 4'd2, 1'b1);
        issue(4'd3, 32'($urandom), 32'($urandom), 4'd3, 1'b1);
        issue(4'd7, 32'h8000_0000, 32'h24, 4'd4, 1'b1);
        issue(4'd8, 32'hFFFF_FFFE, 32'd1, 4'd5, 1'b1);
        issue(4'd9, 32'hFFFF_FFFE, 32'd1, 4'd6, 1'b1);
        issue(4'd10, 32'($urandom), 32'($urandom), 4'd7, 1'b1);
        wait_drain();

        watch = 1'b1;
        fork
            for (int i = 0; i < 12; i++)
                issue(4'($urandom_range(0, 10)), rnd_val(), rnd_val(), 4'(i), 1'b0);
            begin
                idle(3);
                rdy_force = 1'b0;
                idle(5);
                rdy_force = 1'b1;
            end
        join
        watch = 1'b0;
        wait_drain();
        chk("in_ready_fell", 64'(saw_block), 64'd1);

        issue(4'd11, 32'd100, 32'd7, 4'd3, 1'b1);
        wait_drain();
        issue(4'd12, 32'd100, 32'd7, 4'd4, 1'b1);
        issue(4'd11, 32'($urandom), 32'd0, 4'd5, 1'b0);
        issue(4'd12, 32'd9, 32'd0, 4'd6, 1'b0);
        issue(4'd11, 32'd1000, 32'd3, 4'd7, 1'b0);
        issue(4'd0, 32'd20, 32'd22, 4'd8, 1'b0);
        wait_drain();

        issue(4'd14, 32'd12, 32'd34, 4'd9, 1'b1);
        wait_drain();

        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            if ((op == 4'd11 || op == 4'd12) && $urandom_range(0, 3) != 0)
                op = 4'($urandom_range(0, 10));
            issue(op, rnd_val(), rnd_val(), 4'(i), 1'b0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rdy_rand = 1'b0;
        wait_drain();

        issue(4'd0, 32'd3, 32'd4, 4'd9, 1'b0);
        wait_drain();
        issue(4'd11, 32'd1234, 32'd0, 4'd5, 1'b0);
        idle(P + 9);
        rst = 1'b0;
        scb.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("div_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("div_rst_result", 64'(bus.result), 64'd0);
        chk("div_rst_tag", 64'(bus.out_tag), 64'd0);
        chk("div_rst_flags", 64'(bus.flags), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        issue(4'd0, 32'd40, 32'd2, 4'd10, 1'b1);
        wait_drain();
        idle(50);
        chk("no_late_output", 64'(scb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
